// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: ALU results have priority, MEM results are queued and
// force a grant once the queue head has waited STARVE_LIMIT cycles.
module cdb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RegWrite_ALU_CDB,
  input  logic [2:0]   WarpID_ALU_CDB,
  input  logic [4:0]   Dst_ALU_CDB,
  input  logic [255:0] Dst_Data_ALU_CDB,
  input  logic [31:0]  Instr_ALU_CDB,
  input  logic [7:0]   ActiveMask_ALU_CDB,
  output logic         Stall_CDB_ALU,
  input  logic         RegWrite_MEM_CDB,
  input  logic [2:0]   WarpID_MEM_CDB,
  input  logic [4:0]   Dst_MEM_CDB,
  input  logic [255:0] Dst_Data_MEM_CDB,
  input  logic [31:0]  Instr_MEM_CDB,
  input  logic [7:0]   ActiveMask_MEM_CDB,
  output logic         Ready_CDB_MEM,
  output logic         RegWrite_CDB_RAU,
  output logic [2:0]   HWWarp_CDB_RAU,
  output logic [4:0]   WriteAddr_CDB_RAU,
  output logic [255:0] Data_CDB_RAU,
  output logic [31:0]  Instr_CDB_RAU,
  output logic [7:0]   ActiveMask_CDB_RAU
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = ($clog2(STARVE_LIMIT + 1) > 2) ? $clog2(STARVE_LIMIT + 1) : 2;
  localparam int PAY_W = 3 + 5 + 256 + 32 + 8;

  typedef enum logic {
    ALU_PRI   = 1'b0,
    MEM_FORCE = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PAY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [AGE_W-1:0]   age;
  logic               fifo_nonempty;
  logic               push;
  logic               pop;
  logic               grant_alu;
  logic               grant_mem;
  logic [PAY_W-1:0]   alu_pay_p0;
  logic [PAY_W-1:0]   mem_pay_p0;
  logic               wb_vld_p1;
  logic [PAY_W-1:0]   wb_pay_p1;

  assign alu_pay_p0 = {WarpID_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB,
                       Instr_ALU_CDB, ActiveMask_ALU_CDB};
  assign mem_pay_p0 = {WarpID_MEM_CDB, Dst_MEM_CDB, Dst_Data_MEM_CDB,
                       Instr_MEM_CDB, ActiveMask_MEM_CDB};

  assign fifo_nonempty = (count != '0);
  // Ready looks only at the registered count so it never waits on a same-cycle pop.
  assign Ready_CDB_MEM = (count != CNT_W'(FIFO_DEPTH));
  assign push          = RegWrite_MEM_CDB && Ready_CDB_MEM;
  assign pop           = grant_mem;

  always_comb begin
    state_next    = state;
    Stall_CDB_ALU = 1'b0;
    grant_alu     = 1'b0;
    grant_mem     = 1'b0;
    case (state)
      ALU_PRI: begin
        if (RegWrite_ALU_CDB) begin
          grant_alu = 1'b1;
          // Head loses this cycle; switch when its age is about to hit the limit.
          if (fifo_nonempty && (age == AGE_W'(STARVE_LIMIT - 1)))
            state_next = MEM_FORCE;
        end else if (fifo_nonempty) begin
          grant_mem = 1'b1;
        end
      end
      MEM_FORCE: begin
        Stall_CDB_ALU = 1'b1;
        grant_mem     = fifo_nonempty;
        state_next    = ALU_PRI;
      end
      default: state_next = ALU_PRI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ALU_PRI;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      age <= '0;
    else if (pop || !fifo_nonempty)
      age <= '0;
    else
      age <= age + AGE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_pay_p0;
  end

  // ---- stage p0 -> p1: granted payload into the RAU writeback register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld_p1 <= 1'b0;
      wb_pay_p1 <= '0;
    end else if (grant_alu) begin
      wb_vld_p1 <= 1'b1;
      wb_pay_p1 <= alu_pay_p0;
    end else if (grant_mem) begin
      wb_vld_p1 <= 1'b1;
      wb_pay_p1 <= fifo_mem[rd_ptr];
    end else begin
      wb_vld_p1 <= 1'b0;
      wb_pay_p1 <= '0;
    end
  end

  assign RegWrite_CDB_RAU = wb_vld_p1;
  assign {HWWarp_CDB_RAU, WriteAddr_CDB_RAU, Data_CDB_RAU,
          Instr_CDB_RAU, ActiveMask_CDB_RAU} = wb_pay_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for single-cycle behaviour plus
// hand-written full-queue and mid-operation reset sequences.
`define CHK(n, a, e) chk(n, 304'(a), 304'(e))

module tb_cdb_arbiter;

  logic         clk;
  logic         rst;
  logic         RegWrite_ALU_CDB;
  logic [2:0]   WarpID_ALU_CDB;
  logic [4:0]   Dst_ALU_CDB;
  logic [255:0] Dst_Data_ALU_CDB;
  logic [31:0]  Instr_ALU_CDB;
  logic [7:0]   ActiveMask_ALU_CDB;
  logic         Stall_CDB_ALU;
  logic         RegWrite_MEM_CDB;
  logic [2:0]   WarpID_MEM_CDB;
  logic [4:0]   Dst_MEM_CDB;
  logic [255:0] Dst_Data_MEM_CDB;
  logic [31:0]  Instr_MEM_CDB;
  logic [7:0]   ActiveMask_MEM_CDB;
  logic         Ready_CDB_MEM;
  logic         RegWrite_CDB_RAU;
  logic [2:0]   HWWarp_CDB_RAU;
  logic [4:0]   WriteAddr_CDB_RAU;
  logic [255:0] Data_CDB_RAU;
  logic [31:0]  Instr_CDB_RAU;
  logic [7:0]   ActiveMask_CDB_RAU;

  cdb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_ALU_CDB(RegWrite_ALU_CDB), .WarpID_ALU_CDB(WarpID_ALU_CDB),
    .Dst_ALU_CDB(Dst_ALU_CDB), .Dst_Data_ALU_CDB(Dst_Data_ALU_CDB),
    .Instr_ALU_CDB(Instr_ALU_CDB), .ActiveMask_ALU_CDB(ActiveMask_ALU_CDB),
    .Stall_CDB_ALU(Stall_CDB_ALU),
    .RegWrite_MEM_CDB(RegWrite_MEM_CDB), .WarpID_MEM_CDB(WarpID_MEM_CDB),
    .Dst_MEM_CDB(Dst_MEM_CDB), .Dst_Data_MEM_CDB(Dst_Data_MEM_CDB),
    .Instr_MEM_CDB(Instr_MEM_CDB), .ActiveMask_MEM_CDB(ActiveMask_MEM_CDB),
    .Ready_CDB_MEM(Ready_CDB_MEM),
    .RegWrite_CDB_RAU(RegWrite_CDB_RAU), .HWWarp_CDB_RAU(HWWarp_CDB_RAU),
    .WriteAddr_CDB_RAU(WriteAddr_CDB_RAU), .Data_CDB_RAU(Data_CDB_RAU),
    .Instr_CDB_RAU(Instr_CDB_RAU), .ActiveMask_CDB_RAU(ActiveMask_CDB_RAU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [2:0] aw;
    logic [4:0] ad;
    logic [7:0] at;
    logic       mv;
    logic [2:0] mw;
    logic [4:0] md;
    logic [7:0] mt;
    logic       es;
    logic       er;
    logic       ew;
    logic [2:0] ewp;
    logic [4:0] ea;
    logic [7:0] et;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_q [$];
  logic [7:0] alu_q [$];
  int         mem_sent, mem_out, alu_sent, alu_out;
  logic [7:0] alu_tag;
  logic       alu_on, s_stall, s_ready, s_mv;

  task automatic chk(input string name, input logic [303:0] act, input logic [303:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aw, input logic [4:0] ad,
                       input logic [7:0] at, input logic mv, input logic [2:0] mw,
                       input logic [4:0] md, input logic [7:0] mt);
    RegWrite_ALU_CDB   = av;
    WarpID_ALU_CDB     = aw;
    Dst_ALU_CDB        = ad;
    Dst_Data_ALU_CDB   = {32{at}};
    Instr_ALU_CDB      = {24'h0, at};
    ActiveMask_ALU_CDB = at;
    RegWrite_MEM_CDB   = mv;
    WarpID_MEM_CDB     = mw;
    Dst_MEM_CDB        = md;
    Dst_Data_MEM_CDB   = {32{mt}};
    Instr_MEM_CDB      = {24'h0, mt};
    ActiveMask_MEM_CDB = mt;
  endtask

  task automatic check_rau(input string name, input logic ew, input logic [2:0] ewp,
                           input logic [4:0] ea, input logic [7:0] et);
    `CHK({name, " wr"},    RegWrite_CDB_RAU,   ew);
    `CHK({name, " warp"},  HWWarp_CDB_RAU,     ewp);
    `CHK({name, " addr"},  WriteAddr_CDB_RAU,  ea);
    `CHK({name, " data"},  Data_CDB_RAU,       {32{et}});
    `CHK({name, " instr"}, Instr_CDB_RAU,      {24'h0, et});
    `CHK({name, " mask"},  ActiveMask_CDB_RAU, et);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 5'd0, 8'h00, 1'b0, 3'd0, 5'd0, 8'h00);
  endtask

  initial begin
    //         av    aw    ad     at     mv    mw    md     mt     es    er    ew    ewp   ea     et
    vecs[0]  = '{1'b1, 3'd1, 5'd5,  8'hA5, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 5'd5,  8'hA5};
    vecs[1]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  8'h00};
    vecs[2]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd3, 5'd9,  8'h31, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  8'h00};
    vecs[3]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 5'd9,  8'h31};
    vecs[4]  = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  8'h00};
    vecs[5]  = '{1'b1, 3'd2, 5'd10, 8'h10, 1'b1, 3'd4, 5'd20, 8'h20, 1'b0, 1'b1, 1'b1, 3'd2, 5'd10, 8'h10};
    vecs[6]  = '{1'b1, 3'd2, 5'd11, 8'h11, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'd11, 8'h11};
    vecs[7]  = '{1'b1, 3'd2, 5'd12, 8'h12, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'd12, 8'h12};
    vecs[8]  = '{1'b1, 3'd2, 5'd13, 8'h13, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'd13, 8'h13};
    vecs[9]  = '{1'b1, 3'd2, 5'd14, 8'h14, 1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 5'd20, 8'h20};
    vecs[10] = '{1'b1, 3'd2, 5'd14, 8'h14, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'd14, 8'h14};
    vecs[11] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  8'h00};
    vecs[12] = '{1'b1, 3'd0, 5'd1,  8'h41, 1'b1, 3'd5, 5'd21, 8'h51, 1'b0, 1'b1, 1'b1, 3'd0, 5'd1,  8'h41};
    vecs[13] = '{1'b1, 3'd0, 5'd2,  8'h42, 1'b1, 3'd5, 5'd22, 8'h52, 1'b0, 1'b1, 1'b1, 3'd0, 5'd2,  8'h42};
    vecs[14] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b1, 3'd5, 5'd23, 8'h53, 1'b0, 1'b1, 1'b1, 3'd5, 5'd21, 8'h51};
    vecs[15] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 5'd22, 8'h52};
    vecs[16] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 5'd23, 8'h53};
    vecs[17] = '{1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 3'd0, 5'd0,  8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  8'h00};

    rst = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_rau("reset", 1'b0, 3'd0, 5'd0, 8'h00);
    `CHK("reset stall", Stall_CDB_ALU, 1'b0);
    `CHK("reset ready", Ready_CDB_MEM, 1'b1);
    rst = 1'b0;

    // Table: ALU only, MEM only, starvation, simultaneous push/pop at count 2.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].aw, vecs[i].ad, vecs[i].at,
            vecs[i].mv, vecs[i].mw, vecs[i].md, vecs[i].mt);
      @(negedge clk);
      checks++;
      if (Stall_CDB_ALU !== vecs[i].es) begin
        errors++;
        $display("FAIL v%0d stall: got %b, expected %b", i, Stall_CDB_ALU, vecs[i].es);
      end
      checks++;
      if (Ready_CDB_MEM !== vecs[i].er) begin
        errors++;
        $display("FAIL v%0d ready: got %b, expected %b", i, Ready_CDB_MEM, vecs[i].er);
      end
      @(posedge clk);
      #1;
      check_rau($sformatf("v%0d", i), vecs[i].ew, vecs[i].ewp, vecs[i].ea, vecs[i].et);
    end

    // Full queue: ALU continuously valid, MEM offers five results.
    mem_sent = 0; mem_out = 0; alu_sent = 0; alu_out = 0; alu_tag = 8'h80;
    for (int c = 0; c < 40; c++) begin
      alu_on = (c < 24);
      drive(alu_on, 3'd1, 5'd7, alu_tag, (mem_sent < 5), 3'd6,
            5'(16 + mem_sent), 8'(8'hC1 + mem_sent));
      @(negedge clk);
      s_stall = Stall_CDB_ALU;
      s_ready = Ready_CDB_MEM;
      s_mv    = RegWrite_MEM_CDB;
      if (c == 3) `CHK("fq ready before 4th push", s_ready, 1'b1);
      if (c == 4) begin
        `CHK("fq ready full", s_ready, 1'b0);
        `CHK("fq forced stall", s_stall, 1'b1);
      end
      if (c == 5) `CHK("fq ready after forced pop", s_ready, 1'b1);
      if (c == 6) `CHK("fq ready full again", s_ready, 1'b0);
      @(posedge clk);
      #1;
      if (s_mv && s_ready) begin
        mem_q.push_back(8'(8'hC1 + mem_sent));
        mem_sent++;
      end
      if (alu_on && !s_stall) begin
        alu_q.push_back(alu_tag);
        alu_sent++;
        alu_tag = alu_tag + 8'd1;
      end
      if (c == 4) begin
        `CHK("fq first forced warp", HWWarp_CDB_RAU, 3'd6);
        `CHK("fq first forced tag", ActiveMask_CDB_RAU, 8'hC1);
      end
      if (RegWrite_CDB_RAU) begin
        if (HWWarp_CDB_RAU == 3'd6) begin
          `CHK("fq mem pending", (mem_q.size() > 0), 1'b1);
          if (mem_q.size() > 0) begin
            `CHK("fq mem order", ActiveMask_CDB_RAU, mem_q.pop_front());
            mem_out++;
          end
        end else begin
          `CHK("fq alu pending", (alu_q.size() > 0), 1'b1);
          if (alu_q.size() > 0) begin
            `CHK("fq alu order", ActiveMask_CDB_RAU, alu_q.pop_front());
            alu_out++;
          end
        end
      end
    end
    `CHK("fq mem pushes", mem_sent, 5);
    `CHK("fq mem writes", mem_out, 5);
    `CHK("fq alu writes", alu_out, alu_sent);

    // Reset mid-operation with three entries queued while in MEM_FORCE.
    idle();
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 3'd1, 5'd3, 8'(8'hE0 + c), (c < 3), 3'd6, 5'(24 + c), 8'(8'hD1 + c));
      @(negedge clk);
      if (c == 4) begin
        `CHK("rst pre stall", Stall_CDB_ALU, 1'b1);
        `CHK("rst pre ready", Ready_CDB_MEM, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_rau("rst async", 1'b0, 3'd0, 5'd0, 8'h00);
        `CHK("rst async stall", Stall_CDB_ALU, 1'b0);
        `CHK("rst async ready", Ready_CDB_MEM, 1'b1);
      end
      @(posedge clk);
      #1;
    end
    check_rau("rst held", 1'b0, 3'd0, 5'd0, 8'h00);
    rst = 1'b0;
    idle();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (RegWrite_CDB_RAU !== 1'b0) begin
        errors++;
        $display("FAIL post rst %0d wr: got %b, expected 0", c, RegWrite_CDB_RAU);
      end
      checks++;
      if (Ready_CDB_MEM !== 1'b1) begin
        errors++;
        $display("FAIL post rst %0d ready: got %b, expected 1", c, Ready_CDB_MEM);
      end
    end
    drive(1'b1, 3'd7, 5'd30, 8'h77, 1'b0, 3'd0, 5'd0, 8'h00);
    @(posedge clk);
    #1;
    check_rau("post rst alu", 1'b1, 3'd7, 5'd30, 8'h77);
    idle();
    @(posedge clk);
    #1;
    check_rau("post rst idle", 1'b0, 3'd0, 5'd0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
